// File: rtl/irrigation_pkg.sv
// Shared state codes, default run lengths and the saturating run-counter helper
// for the irrigation scheduler.
package irrigation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPRINKLE = 3'd1,
    ST_DRIP     = 3'd2,
    ST_SOAK     = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_e;

  localparam int DEF_SPRINKLE_TICKS = 10;
  localparam int DEF_DRIP_TICKS     = 20;
  localparam int DEF_SOAK_TICKS     = 5;
  localparam int DEF_CNT_W          = 8;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/irrigation_scheduler_if.sv
// Sensor/request inputs and valve/status outputs of the irrigation scheduler.
// tick_i is a level strobe: every clk it is high counts as one tick, there is no ready/ack.
interface irrigation_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             tick_i;
  logic             error_i;
  logic             alarm_i;
  logic             soil_dry_i;
  logic             sprinkler_req_i;
  logic             drip_req_i;
  logic             sprinkler_valve_o;
  logic             drip_valve_o;
  logic             busy_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] remaining_o;
  logic [3:0]       cycles_o;

  modport slave (
    input  tick_i, error_i, alarm_i, soil_dry_i, sprinkler_req_i, drip_req_i,
    output sprinkler_valve_o, drip_valve_o, busy_o, state_o, remaining_o, cycles_o
  );

  modport master (
    output tick_i, error_i, alarm_i, soil_dry_i, sprinkler_req_i, drip_req_i,
    input  sprinkler_valve_o, drip_valve_o, busy_o, state_o, remaining_o, cycles_o
  );
endinterface

// File: rtl/irrigation_scheduler_tick_down_counter.sv
// Loadable down-counter: load wins over decrement, decrement stops at zero.
module tick_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);
endmodule

// File: rtl/irrigation_scheduler.sv
// Irrigation run sequencer: sprinkler or drip run, soak pause, fault lockout.
// Valves, state, remaining and run count all change on the same clk edge.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int SPRINKLE_TICKS = DEF_SPRINKLE_TICKS,
  parameter int DRIP_TICKS     = DEF_DRIP_TICKS,
  parameter int SOAK_TICKS     = DEF_SOAK_TICKS,
  parameter int CNT_W          = DEF_CNT_W
) (
  input logic                   clk,
  input logic                   rst,
  irrigation_scheduler_if.slave bus
);
  state_e           state_q, state_d;
  logic             spr_valve_q, spr_valve_d;
  logic             drip_valve_q, drip_valve_d;
  logic [3:0]       cycles_q, cycles_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;
  logic             fault;
  logic             expire;

  tick_down_counter #(.W(CNT_W)) u_remaining (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .count_o    (cnt_value),
    .zero_o     (cnt_zero)
  );

  assign fault  = bus.error_i | bus.alarm_i;
  // A zero count inside a timed state is unreachable with legal parameters; treat it as expired.
  assign expire = bus.tick_i & ((cnt_value == CNT_W'(1)) | cnt_zero);

  always_comb begin
    state_d      = state_q;
    cycles_d     = cycles_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fault) begin
          state_d = ST_LOCKOUT;
        end else if (bus.soil_dry_i && bus.sprinkler_req_i) begin
          state_d      = ST_SPRINKLE;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(SPRINKLE_TICKS);
        end else if (bus.soil_dry_i && bus.drip_req_i) begin
          state_d      = ST_DRIP;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(DRIP_TICKS);
        end
      end
      ST_SPRINKLE, ST_DRIP: begin
        if (fault) begin
          state_d  = ST_LOCKOUT;
          cnt_load = 1'b1;
        end else if (!bus.soil_dry_i) begin
          state_d  = ST_IDLE;
          cnt_load = 1'b1;
        end else if (expire) begin
          state_d      = ST_SOAK;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(SOAK_TICKS);
          cycles_d     = sat_inc4(cycles_q);
        end else begin
          cnt_dec = bus.tick_i;
        end
      end
      ST_SOAK: begin
        if (fault) begin
          state_d  = ST_LOCKOUT;
          cnt_load = 1'b1;
        end else if (expire) begin
          state_d  = ST_IDLE;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = bus.tick_i;
        end
      end
      ST_LOCKOUT: begin
        if (!fault) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_load = 1'b1;
      end
    endcase
    spr_valve_d  = (state_d == ST_SPRINKLE);
    drip_valve_d = (state_d == ST_DRIP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      spr_valve_q  <= 1'b0;
      drip_valve_q <= 1'b0;
      cycles_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      spr_valve_q  <= spr_valve_d;
      drip_valve_q <= drip_valve_d;
      cycles_q     <= cycles_d;
    end
  end

  assign bus.state_o           = state_q;
  assign bus.sprinkler_valve_o = spr_valve_q;
  assign bus.drip_valve_o      = drip_valve_q;
  assign bus.busy_o            = (state_q != ST_IDLE);
  assign bus.remaining_o       = cnt_value;
  assign bus.cycles_o          = cycles_q;
endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler: the driver queues the expected output
// snapshot after each clk edge, the monitor compares it on the following falling edge.
`timescale 1ns/1ps
module tb_irrigation_scheduler;
  localparam int CNT_W = 8;
  localparam int W     = 3 + 1 + 1 + 1 + CNT_W + 4;

  logic clk;
  logic rst;

  irrigation_scheduler_if #(.CNT_W(CNT_W)) bus ();

  irrigation_scheduler #(
    .SPRINKLE_TICKS (10),
    .DRIP_TICKS     (20),
    .SOAK_TICKS     (5),
    .CNT_W          (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks;
  int           n_pass;
  int           exp_cyc;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic push_exp(input logic [2:0] st, input int rem, input int cyc, input string nm);
    logic spr, drip, busy;
    spr  = (st == 3'd1);
    drip = (st == 3'd2);
    busy = (st != 3'd0);
    exp_q.push_back({st, spr, drip, busy, CNT_W'(rem), 4'(cyc)});
    name_q.push_back(nm);
  endtask

  task automatic expect_next(input logic [2:0] st, input int rem, input int cyc, input string nm);
    @(posedge clk);
    push_exp(st, rem, cyc, nm);
    @(negedge clk);
    #1;
  endtask

  task automatic full_run();
    bus.soil_dry_i      = 1'b1;
    bus.sprinkler_req_i = 1'b1;
    expect_next(3'd1, 10, exp_cyc, "sat_start");
    bus.tick_i = 1'b1;
    for (int i = 1; i < 10; i++) expect_next(3'd1, 10 - i, exp_cyc, "sat_spr");
    exp_cyc = (exp_cyc < 15) ? exp_cyc + 1 : 15;
    expect_next(3'd3, 5, exp_cyc, "sat_soak_entry");
    bus.soil_dry_i      = 1'b0;
    bus.sprinkler_req_i = 1'b0;
    for (int i = 1; i < 5; i++) expect_next(3'd3, 5 - i, exp_cyc, "sat_soak");
    expect_next(3'd0, 0, exp_cyc, "sat_idle");
    bus.tick_i = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] exp_v, act_v;
    string        nm;
    n_checks = 0;
    n_pass   = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {bus.state_o, bus.sprinkler_valve_o, bus.drip_valve_o, bus.busy_o,
                 bus.remaining_o, bus.cycles_o};
        n_checks++;
        if (act_v === exp_v) begin
          n_pass++;
        end else begin
          $display("FAIL %s @%0t: got state=%0d spr=%b drip=%b busy=%b rem=%0d cyc=%0d, expected state=%0d spr=%b drip=%b busy=%b rem=%0d cyc=%0d",
                   nm, $time, act_v[W-1 -: 3], act_v[W-4], act_v[W-5], act_v[W-6],
                   act_v[4 +: CNT_W], act_v[3:0], exp_v[W-1 -: 3], exp_v[W-4],
                   exp_v[W-5], exp_v[W-6], exp_v[4 +: CNT_W], exp_v[3:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst                 = 1'b1;
    bus.tick_i          = 1'b0;
    bus.error_i         = 1'b0;
    bus.alarm_i         = 1'b0;
    bus.soil_dry_i      = 1'b0;
    bus.sprinkler_req_i = 1'b0;
    bus.drip_req_i      = 1'b0;
    exp_cyc             = 0;
    push_exp(3'd0, 0, 0, "reset");
    @(negedge clk);
    #1;
    rst = 1'b0;
    expect_next(3'd0, 0, 0, "idle_quiet");

    // sprinkler run with a gap cycle between ticks
    bus.soil_dry_i      = 1'b1;
    bus.sprinkler_req_i = 1'b1;
    expect_next(3'd1, 10, 0, "spr_start");
    for (int i = 1; i <= 10; i++) begin
      bus.tick_i = 1'b1;
      if (i < 10) expect_next(3'd1, 10 - i, 0, "spr_tick");
      else        expect_next(3'd3, 5, 1, "spr_to_soak");
      bus.tick_i = 1'b0;
      if (i < 10) expect_next(3'd1, 10 - i, 0, "spr_hold");
    end
    bus.soil_dry_i      = 1'b0;
    bus.sprinkler_req_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus.tick_i = 1'b1;
      if (i < 5) expect_next(3'd3, 5 - i, 1, "soak_tick");
      else       expect_next(3'd0, 0, 1, "soak_to_idle");
      bus.tick_i = 1'b0;
    end

    // both requests: sprinkler wins; request change mid-run is ignored; soil drop aborts
    bus.soil_dry_i      = 1'b1;
    bus.sprinkler_req_i = 1'b1;
    bus.drip_req_i      = 1'b1;
    expect_next(3'd1, 10, 1, "both_req_spr");
    bus.sprinkler_req_i = 1'b0;
    bus.tick_i          = 1'b1;
    expect_next(3'd1, 9, 1, "req_change_ignored");
    bus.tick_i     = 1'b0;
    bus.soil_dry_i = 1'b0;
    expect_next(3'd0, 0, 1, "soil_drop_abort");

    // drip run with tick held high every clk
    bus.soil_dry_i = 1'b1;
    expect_next(3'd2, 20, 1, "drip_start");
    bus.tick_i = 1'b1;
    for (int i = 1; i < 20; i++) expect_next(3'd2, 20 - i, 1, "drip_tick");
    expect_next(3'd3, 5, 2, "drip_to_soak");
    bus.soil_dry_i = 1'b0;
    bus.drip_req_i = 1'b0;
    for (int i = 1; i < 5; i++) expect_next(3'd3, 5 - i, 2, "drip_soak");
    expect_next(3'd0, 0, 2, "drip_soak_idle");
    bus.tick_i = 1'b0;

    // alarm at remaining=3 in DRIP
    bus.soil_dry_i = 1'b1;
    bus.drip_req_i = 1'b1;
    expect_next(3'd2, 20, 2, "alarm_drip_start");
    bus.tick_i = 1'b1;
    for (int i = 1; i <= 17; i++) expect_next(3'd2, 20 - i, 2, "alarm_drip_tick");
    bus.tick_i  = 1'b0;
    bus.alarm_i = 1'b1;
    expect_next(3'd4, 0, 2, "alarm_lockout");
    expect_next(3'd4, 0, 2, "alarm_lockout_hold");
    bus.alarm_i    = 1'b0;
    bus.soil_dry_i = 1'b0;
    bus.drip_req_i = 1'b0;
    expect_next(3'd0, 0, 2, "alarm_release_idle");

    // fault beats a start request in IDLE
    bus.error_i         = 1'b1;
    bus.soil_dry_i      = 1'b1;
    bus.sprinkler_req_i = 1'b1;
    expect_next(3'd4, 0, 2, "idle_fault_priority");
    bus.error_i         = 1'b0;
    bus.soil_dry_i      = 1'b0;
    bus.sprinkler_req_i = 1'b0;
    expect_next(3'd0, 0, 2, "idle_fault_release");

    // error together with the final tick: lockout, no count
    bus.soil_dry_i      = 1'b1;
    bus.sprinkler_req_i = 1'b1;
    expect_next(3'd1, 10, 2, "err_tick_start");
    bus.tick_i = 1'b1;
    for (int i = 1; i <= 9; i++) expect_next(3'd1, 10 - i, 2, "err_tick_run");
    bus.error_i = 1'b1;
    expect_next(3'd4, 0, 2, "err_on_last_tick");
    bus.error_i         = 1'b0;
    bus.tick_i          = 1'b0;
    bus.soil_dry_i      = 1'b0;
    bus.sprinkler_req_i = 1'b0;
    expect_next(3'd0, 0, 2, "err_release_idle");

    // asynchronous reset mid-SPRINKLE
    bus.soil_dry_i      = 1'b1;
    bus.sprinkler_req_i = 1'b1;
    expect_next(3'd1, 10, 2, "rst_pre_start");
    bus.tick_i = 1'b1;
    expect_next(3'd1, 9, 2, "rst_pre_tick");
    bus.tick_i = 1'b0;
    @(posedge clk);
    push_exp(3'd1, 9, 2, "rst_pre_hold");
    @(negedge clk);
    #1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    push_exp(3'd0, 0, 0, "rst_async_zero");
    @(negedge clk);
    #1;
    rst                 = 1'b0;
    bus.soil_dry_i      = 1'b0;
    bus.sprinkler_req_i = 1'b0;
    expect_next(3'd0, 0, 0, "rst_release_idle");
    bus.soil_dry_i      = 1'b1;
    bus.sprinkler_req_i = 1'b1;
    expect_next(3'd1, 10, 0, "rst_fresh_start");
    bus.soil_dry_i      = 1'b0;
    bus.sprinkler_req_i = 1'b0;
    expect_next(3'd0, 0, 0, "rst_fresh_abort");

    // 17 complete runs from a cleared counter saturate at 15
    exp_cyc = 0;
    for (int r = 0; r < 17; r++) full_run();
    expect_next(3'd0, 0, 15, "sat_final");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/irrigation_scheduler.md
IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 The block SHALL have parameter SPRINKLE_TICKS, default 10, sprinkler run length in ticks (legal 1..2^CNT_W-1).
REQ-002 The block SHALL have parameter DRIP_TICKS, default 20, drip run length in ticks (legal 1..2^CNT_W-1).
REQ-003 The block SHALL have parameter SOAK_TICKS, default 5, post-run soak pause in ticks (legal 1..2^CNT_W-1).
REQ-004 The block SHALL have parameter CNT_W, default 8, width of the tick counter.
REQ-005 The block SHALL have port clk, input, 1, the single system clock.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port tick_i, input, 1, one-clk timing strobe from the frequency divider.
REQ-008 The block SHALL have port error_i, input, 1, level-sensor inconsistency flag.
REQ-009 The block SHALL have port alarm_i, input, 1, tank-low alarm.
REQ-010 The block SHALL have port soil_dry_i, input, 1, soil needs water.
REQ-011 The block SHALL have port sprinkler_req_i, input, 1, climate logic requests sprinkler mode.
REQ-012 The block SHALL have port drip_req_i, input, 1, climate logic requests drip mode.
REQ-013 The block SHALL have port sprinkler_valve_o, output, 1, registered sprinkler valve drive.
REQ-014 The block SHALL have port drip_valve_o, output, 1, registered drip valve drive.
REQ-015 The block SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-016 The block SHALL have port state_o, output, 3, current state code.
REQ-017 The block SHALL have port remaining_o, output, CNT_W, ticks left in the current timed state, 0 otherwise.
REQ-018 The block SHALL have port cycles_o, output, 4, completed irrigation runs, saturating.

Function
REQ-019 The FSM SHALL use state codes IDLE=0, SPRINKLE=1, DRIP=2, SOAK=3, LOCKOUT=4; codes 5-7 SHALL return to IDLE on the next clk.
REQ-020 The FSM SHALL register state_o, both valve outputs, remaining_o and cycles_o, with all of them updating on the same clk edge as the state change.
REQ-021 In IDLE, error_i|alarm_i SHALL move the FSM to LOCKOUT, taking priority over any start.
REQ-022 In IDLE without fault, soil_dry_i&sprinkler_req_i SHALL move the FSM to SPRINKLE with remaining=SPRINKLE_TICKS.
REQ-023 In IDLE without fault, soil_dry_i&drip_req_i&!sprinkler_req_i SHALL move the FSM to DRIP with remaining=DRIP_TICKS; if both requests are set, sprinkler wins.
REQ-024 In SPRINKLE/DRIP, each tick_i SHALL decrement remaining; a tick_i with remaining==1 SHALL load SOAK with remaining=SOAK_TICKS and increment cycles_o, saturating at 15.
REQ-025 In SPRINKLE/DRIP, soil_dry_i low SHALL move the FSM to IDLE with remaining=0 and no cycles_o increment; fault takes priority over this exit.
REQ-026 In SPRINKLE, SOAK or DRIP, error_i|alarm_i SHALL move the FSM to LOCKOUT with remaining=0 on the next clk, overriding a simultaneous tick_i or expiry.
REQ-027 In SOAK, each tick_i SHALL decrement remaining; a tick_i with remaining==1 SHALL move the FSM to IDLE; both valves stay off.
REQ-028 In LOCKOUT, the FSM SHALL hold while error_i|alarm_i is high and move to IDLE on the first clk where both are low.
REQ-029 sprinkler_valve_o SHALL be 1 iff state is SPRINKLE, and drip_valve_o 1 iff state is DRIP; both 1 at once SHALL never occur.
REQ-030 Request changes mid-run SHALL NOT switch mode; only soil_dry_i, fault or expiry end a run.
REQ-031 tick_i held high for multiple clks SHALL count once per clk it is high.

Reset
REQ-032 On rst the block SHALL asynchronously enter IDLE with both valves 0, busy_o 0, remaining_o 0 and cycles_o 0, regardless of state.
REQ-033 On rst deassertion the block SHALL evaluate inputs on the first following clk edge; a run interrupted by rst SHALL NOT resume.

Structure
REQ-034 The state codes and default tick constants SHALL live in shared package irrigation_pkg.
REQ-035 The block SHALL instantiate one sub-module, tick_down_counter (load, tick-enable decrement, zero flag), for remaining.

Verification
REQ-036 Bench SHALL check: soil_dry=1, sprinkler_req=1, 10 ticks -> sprinkler_valve 1 for exactly 10 ticks, then SOAK for 5, then IDLE with cycles_o=1.
REQ-037 Bench SHALL check: both requests=1 in IDLE -> SPRINKLE chosen; drip_req alone -> drip_valve 1 for 20 ticks.
REQ-038 Bench SHALL check: alarm_i pulse at remaining=3 in DRIP -> next clk LOCKOUT with valves 0 and remaining 0; alarm low -> IDLE next clk.
REQ-039 Bench SHALL check: error_i and final tick_i on the same clk -> LOCKOUT, cycles_o unchanged.
REQ-040 Bench SHALL check: 17 completed runs -> cycles_o=15; soil_dry dropped mid-run -> IDLE, no increment.
REQ-041 Bench SHALL check: rst asserted mid-SPRINKLE between clk edges -> outputs zero immediately, IDLE after release.
